// File: rtl/gpmc_slave_ctrl.sv
// GPMC muxed-bus slave: synchronizes host strobes, sequences addr/write/read phases,
// and maps accesses onto STATUS/TX_DATA/RX_DATA/SCRATCH/ID plus two FWFT FIFOs.
module gpmc_slave_ctrl #(
  parameter int          FIFO_AW  = 4,
  parameter logic [15:0] ID_VALUE = 16'hB5D0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] gpmc_ad_in,
  output logic [15:0] gpmc_ad_out,
  output logic        gpmc_ad_oe,
  input  logic        gpmc_ncs,
  input  logic        gpmc_nadv,
  input  logic        gpmc_nwe,
  input  logic        gpmc_noe,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_data_ok,
  output logic        rx_data_ok
);
  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [2:0] {IDLE, ADDR, CMD, WR, RD, DONE} state_t;

  logic [1:0]  ncs_sync, nadv_sync, nwe_sync, noe_sync;
  logic [15:0] ad_p1, ad_s;
  logic        nadv_d, nwe_d, noe_d;
  logic        ncs_s, nadv_s, nwe_s, noe_s;
  logic        nadv_rise, nwe_rise, noe_rise;

  // AD goes through the same two stages as the strobes so it stays aligned with them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_sync  <= 2'b11;
      nadv_sync <= 2'b11;
      nwe_sync  <= 2'b11;
      noe_sync  <= 2'b11;
      ad_p1     <= '0;
      ad_s      <= '0;
      nadv_d    <= 1'b1;
      nwe_d     <= 1'b1;
      noe_d     <= 1'b1;
    end else begin
      ncs_sync  <= {ncs_sync[0], gpmc_ncs};
      nadv_sync <= {nadv_sync[0], gpmc_nadv};
      nwe_sync  <= {nwe_sync[0], gpmc_nwe};
      noe_sync  <= {noe_sync[0], gpmc_noe};
      ad_p1     <= gpmc_ad_in;
      ad_s      <= ad_p1;
      nadv_d    <= nadv_sync[1];
      nwe_d     <= nwe_sync[1];
      noe_d     <= noe_sync[1];
    end
  end

  assign ncs_s     = ncs_sync[1];
  assign nadv_s    = nadv_sync[1];
  assign nwe_s     = nwe_sync[1];
  assign noe_s     = noe_sync[1];
  assign nadv_rise = nadv_s & ~nadv_d;
  assign nwe_rise  = nwe_s & ~nwe_d;
  assign noe_rise  = noe_s & ~noe_d;

  state_t state, state_nx;
  logic   addr_latch, rd_start, rd_end, wr_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ncs_s) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (!nadv_s) state_nx = ADDR;
        ADDR:    if (nadv_rise) state_nx = CMD;
        CMD:     if (!nwe_s) state_nx = WR;
                 else if (!noe_s) state_nx = RD;
        WR:      if (nwe_rise) state_nx = DONE;
        RD:      if (noe_rise) state_nx = DONE;
        DONE:    if (!nadv_s) state_nx = ADDR;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    addr_latch = 1'b0;
    rd_start   = 1'b0;
    rd_end     = 1'b0;
    wr_pulse   = 1'b0;
    if (!ncs_s) begin
      case (state)
        ADDR:    addr_latch = nadv_rise;
        CMD:     rd_start   = nwe_s & ~noe_s;
        WR:      wr_pulse   = nwe_rise;
        RD:      rd_end     = noe_rise;
        default: ;
      endcase
    end
  end

  logic [15:0]        tx_mem [DEPTH];
  logic [15:0]        rx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [FIFO_AW:0]   tx_cnt, rx_cnt, tx_cnt_nx, rx_cnt_nx;
  logic [3:0]         addr;
  logic [15:0]        scratch, status_word, rd_mux;
  logic               tx_overflow, rx_underflow, rd_was_empty;
  logic               tx_full, rx_empty;
  logic               tx_push_req, tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full     = (tx_cnt == CNT_FULL);
  assign rx_empty    = (rx_cnt == '0);
  assign tx_valid    = (tx_cnt != '0);
  assign tx_data     = tx_mem[tx_rp];
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = wr_pulse && (addr == 4'd1);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_push     = rx_valid & rx_ready;
  // Pop only what the host actually saw: emptiness is judged when the read data was frozen
  assign rx_pop      = rd_end && (addr == 4'd2) && !rd_was_empty;

  always_comb begin
    tx_cnt_nx = tx_cnt;
    if (tx_push && !tx_pop)      tx_cnt_nx = tx_cnt + CNT_ONE;
    else if (!tx_push && tx_pop) tx_cnt_nx = tx_cnt - CNT_ONE;
    rx_cnt_nx = rx_cnt;
    if (rx_push && !rx_pop)      rx_cnt_nx = rx_cnt + CNT_ONE;
    else if (!rx_push && rx_pop) rx_cnt_nx = rx_cnt - CNT_ONE;
  end

  assign status_word = {8'(rx_cnt), 4'b0000, rx_underflow, tx_overflow, rx_data_ok, tx_data_ok};

  always_comb begin
    rd_mux = '0;
    case (addr)
      4'd0:    rd_mux = status_word;
      4'd2:    rd_mux = rx_empty ? 16'h0000 : rx_mem[rx_rp];
      4'd3:    rd_mux = scratch;
      4'd4:    rd_mux = ID_VALUE;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp        <= '0;
      tx_rp        <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      tx_data_ok   <= 1'b1;
      rx_data_ok   <= 1'b0;
      rx_ready     <= 1'b1;
      addr         <= '0;
      scratch      <= '0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      rd_was_empty <= 1'b0;
      gpmc_ad_out  <= '0;
      gpmc_ad_oe   <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      tx_cnt     <= tx_cnt_nx;
      rx_cnt     <= rx_cnt_nx;
      tx_data_ok <= (tx_cnt_nx != CNT_FULL);
      rx_data_ok <= (rx_cnt_nx != '0);
      rx_ready   <= (rx_cnt_nx != CNT_FULL);
      if (addr_latch) addr <= ad_s[3:0];
      if (wr_pulse && addr == 4'd3) scratch <= ad_s;
      if (tx_push_req && !tx_push)                   tx_overflow <= 1'b1;
      else if (wr_pulse && addr == 4'd0 && ad_s[2]) tx_overflow <= 1'b0;
      if (rd_end && addr == 4'd2 && rd_was_empty)    rx_underflow <= 1'b1;
      else if (wr_pulse && addr == 4'd0 && ad_s[3]) rx_underflow <= 1'b0;
      if (rd_start) begin
        gpmc_ad_out  <= rd_mux;
        rd_was_empty <= rx_empty;
      end
      gpmc_ad_oe <= (state_nx == RD);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= ad_s;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

endmodule

// File: tb/tb_gpmc_slave_ctrl.sv
// Bench for gpmc_slave_ctrl: host bus tasks queue expected read data, separate monitors
// compare host read samples and TX FIFO pops against those queues.
`timescale 1ns/1ps
module tb_gpmc_slave_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] gpmc_ad_in;
  logic [15:0] gpmc_ad_out;
  logic        gpmc_ad_oe;
  logic        gpmc_ncs, gpmc_nadv, gpmc_nwe, gpmc_noe;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic        tx_data_ok, rx_data_ok;

  always #10 clk = ~clk;

  gpmc_slave_ctrl #(.FIFO_AW(4), .ID_VALUE(16'hB5D0)) dut (
    .clk(clk), .rst_n(rst_n),
    .gpmc_ad_in(gpmc_ad_in), .gpmc_ad_out(gpmc_ad_out), .gpmc_ad_oe(gpmc_ad_oe),
    .gpmc_ncs(gpmc_ncs), .gpmc_nadv(gpmc_nadv), .gpmc_nwe(gpmc_nwe), .gpmc_noe(gpmc_noe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data_ok(tx_data_ok), .rx_data_ok(rx_data_ok)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [15:0] tx_exp[$];
  event        rd_ev;
  logic [15:0] rd_cap;
  logic        rx_en = 1'b0;
  logic [15:0] rx_step = 16'h0001;
  int          rdy_rise = 0;
  logic        rdy_prev = 1'b1;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Read monitor
  initial begin
    forever begin
      @(rd_ev);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got 0x%04h, expected no read", rd_cap);
      end else begin
        check(name_q.pop_front(), rd_cap, exp_q.pop_front());
      end
    end
  end

  // TX pop monitor and rx_ready rise counter, sampled mid-low-phase
  initial begin
    forever begin
      @(negedge clk);
      #5;
      if (tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_tx_pop: got 0x%04h, expected no pop", tx_data);
        end else begin
          check("tx_order", tx_data, tx_exp.pop_front());
        end
      end
      if (rx_ready && !rdy_prev) rdy_rise++;
      rdy_prev = rx_ready;
    end
  end

  // Datapath source: advances the offered word after each accepted beat
  initial begin
    logic acc;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      if (acc) rx_data = rx_data + rx_step;
      rx_valid = rx_en;
      acc = rx_valid && rx_ready;
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got no finish, expected finish within 1 ms");
    $fatal(1, "timeout");
  end

  task automatic bus_addr(input logic [3:0] a);
    @(negedge clk);
    gpmc_ncs   = 1'b0;
    gpmc_nadv  = 1'b0;
    gpmc_ad_in = {12'h000, a};
    repeat (3) @(negedge clk);
    gpmc_nadv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d);
    bus_addr(a);
    gpmc_ad_in = d;
    gpmc_nwe   = 1'b0;
    repeat (5) @(negedge clk);
    gpmc_nwe = 1'b1;
    repeat (4) @(negedge clk);
    gpmc_ncs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic host_read(input logic [3:0] a, input logic [15:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus_addr(a);
    check_bit("oe_before_noe", gpmc_ad_oe, 1'b0);
    gpmc_noe = 1'b0;
    repeat (7) @(negedge clk);
    check_bit("oe_during_noe", gpmc_ad_oe, 1'b1);
    rd_cap = gpmc_ad_out;
    -> rd_ev;
    gpmc_noe = 1'b1;
    repeat (4) @(negedge clk);
    check_bit("oe_after_noe", gpmc_ad_oe, 1'b0);
    gpmc_ncs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    gpmc_ncs = 1'b1; gpmc_nadv = 1'b1; gpmc_nwe = 1'b1; gpmc_noe = 1'b1;
    gpmc_ad_in = 16'h0000; tx_ready = 1'b0; rx_data = 16'h0000; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_bit("rst_oe", gpmc_ad_oe, 1'b0);
    check("rst_ad_out", gpmc_ad_out, 16'h0000);
    check_bit("rst_tx_valid", tx_valid, 1'b0);
    check_bit("rst_rx_data_ok", rx_data_ok, 1'b0);
    check_bit("rst_tx_data_ok", tx_data_ok, 1'b1);
    check_bit("rst_rx_ready", rx_ready, 1'b1);

    host_read(4'd4, 16'hB5D0, "id");
    host_read(4'd0, 16'h0001, "status_reset");
    host_write(4'd3, 16'hA5A5);
    host_read(4'd3, 16'hA5A5, "scratch");
    host_write(4'd9, 16'h1234);
    host_read(4'd9, 16'h0000, "unmapped");
    host_read(4'd3, 16'hA5A5, "scratch_kept");
    host_read(4'd1, 16'h0000, "tx_data_read");

    // TX fill to full, overflow, clear, drain
    for (int i = 1; i <= 16; i++) begin
      tx_exp.push_back(16'(i));
      host_write(4'd1, 16'(i));
      if (i == 15) check_bit("tx_ok_at_15", tx_data_ok, 1'b1);
      if (i == 16) check_bit("tx_ok_at_16", tx_data_ok, 1'b0);
    end
    host_write(4'd1, 16'h0011);
    host_read(4'd0, 16'h0004, "status_tx_ovf");
    host_write(4'd0, 16'h0004);
    host_read(4'd0, 16'h0000, "status_ovf_clr");
    tx_ready = 1'b1;
    repeat (24) @(negedge clk);
    tx_ready = 1'b0;
    @(negedge clk);
    check_bit("tx_drained_valid", tx_valid, 1'b0);
    check("tx_drained_left", 16'(tx_exp.size()), 16'h0000);
    check_bit("tx_drained_ok", tx_data_ok, 1'b1);

    // Two datapath words, read them, then underflow
    rx_data = 16'h1111;
    rx_step = 16'h1111;
    @(posedge clk); #1 rx_en = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rx_en = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("rx_ok_two", rx_data_ok, 1'b1);
    host_read(4'd0, 16'h0203, "status_rx2");
    host_read(4'd2, 16'h1111, "rx_first");
    host_read(4'd2, 16'h2222, "rx_second");
    host_read(4'd2, 16'h0000, "rx_empty_read");
    host_read(4'd0, 16'h0009, "status_unf");
    check_bit("rx_ok_empty", rx_data_ok, 1'b0);
    host_write(4'd0, 16'h0008);
    host_read(4'd0, 16'h0001, "status_unf_clr");

    // RX full with continuous datapath pressure while the host reads
    rx_data = 16'h0100;
    rx_step = 16'h0001;
    @(posedge clk); #1 rx_en = 1'b1;
    repeat (24) @(negedge clk);
    check_bit("rx_ready_full", rx_ready, 1'b0);
    host_read(4'd0, 16'h1003, "status_full");
    rdy_rise = 0;
    for (int i = 0; i < 4; i++) host_read(4'd2, 16'h0100 + 16'(i), "rx_full_read");
    repeat (4) @(negedge clk);
    check("rx_ready_rises", 16'(rdy_rise), 16'h0004);
    check_bit("rx_ready_refull", rx_ready, 1'b0);
    host_read(4'd0, 16'h1003, "status_refilled");
    @(posedge clk); #1 rx_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 4; i < 20; i++) host_read(4'd2, 16'h0100 + 16'(i), "rx_drain");
    check_bit("rx_ok_drained", rx_data_ok, 1'b0);

    // Cycle aborted by ncs before nWE rises
    @(negedge clk);
    gpmc_ncs = 1'b0; gpmc_nadv = 1'b0; gpmc_ad_in = 16'h0001;
    repeat (3) @(negedge clk);
    gpmc_nadv = 1'b1;
    repeat (4) @(negedge clk);
    gpmc_ad_in = 16'hDEAD; gpmc_nwe = 1'b0;
    repeat (5) @(negedge clk);
    gpmc_ncs = 1'b1;
    repeat (4) @(negedge clk);
    gpmc_nwe = 1'b1;
    repeat (6) @(negedge clk);
    check_bit("abort_no_push", tx_valid, 1'b0);
    tx_exp.push_back(16'hBEEF);
    host_write(4'd1, 16'hBEEF);
    check_bit("after_abort_push", tx_valid, 1'b1);
    host_write(4'd3, 16'h5A5A);
    host_read(4'd3, 16'h5A5A, "after_abort_scratch");
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    tx_ready = 1'b0;
    check("after_abort_tx_left", 16'(tx_exp.size()), 16'h0000);

    // Reset in the middle of a read
    bus_addr(4'd4);
    gpmc_noe = 1'b0;
    repeat (7) @(negedge clk);
    check_bit("oe_before_rst", gpmc_ad_oe, 1'b1);
    #3 rst_n = 1'b0;
    #1 check_bit("oe_async_rst", gpmc_ad_oe, 1'b0);
    gpmc_ncs = 1'b1; gpmc_noe = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("rst2_tx_valid", tx_valid, 1'b0);
    check_bit("rst2_rx_ready", rx_ready, 1'b1);
    host_read(4'd4, 16'hB5D0, "id_after_rst");
    host_read(4'd3, 16'h0000, "scratch_after_rst");

    repeat (2) @(negedge clk);
    check("reads_pending", 16'(exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
